// File: rtl/ipm2l_hsstlp_rst_debounce_mc_v2_0.sv
// ----------------------------------------------------------------------------
// ipm2l_hsstlp_rst_debounce_mc_v2_0
//
// Purpose:
//   Multi-channel, bidirectional debounce filter for HSSTLP reset/status lines
//   (PLL lock, CDR lock, external reset pins, signal-detect). Each channel
//   first normalises its raw pin so that 1 means "released/good". It then
//   synchronises that value through two flops. The qualified state q only
//   changes after a run of consecutive opposite samples. Rise and fall use
//   separate run lengths.
//
// Ports:
//   clk          in   single clock for all logic
//   rst_n        in   asynchronous active-low reset
//   signal_b     in   [CH_NUM] raw asynchronous inputs
//   clr_flags    in   one-cycle pulse, clears every bounce_flag bit
//   signal_deb   out  [CH_NUM] qualified state in pin polarity (q ^ ACTIVE_HIGH)
//   rise_pls     out  [CH_NUM] one-cycle strobe on q 0->1
//   fall_pls     out  [CH_NUM] one-cycle strobe on q 1->0
//   all_deb      out  registered AND of all q bits (lags q by one cycle)
//   bounce_flag  out  [CH_NUM] sticky: a qualification run was aborted
// ----------------------------------------------------------------------------
module ipm2l_hsstlp_rst_debounce_mc_v2_0 #(
    parameter int                     CH_NUM          = 4,
    parameter int                     CNTR_WIDTH      = 12,
    parameter logic [CNTR_WIDTH-1:0]  RISE_CNTR_VALUE = 12'd2048,
    parameter logic [CNTR_WIDTH-1:0]  FALL_CNTR_VALUE = 12'd1,
    parameter logic [CH_NUM-1:0]      ACTIVE_HIGH     = {CH_NUM{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] signal_b,
    input  logic              clr_flags,
    output logic [CH_NUM-1:0] signal_deb,
    output logic [CH_NUM-1:0] rise_pls,
    output logic [CH_NUM-1:0] fall_pls,
    output logic              all_deb,
    output logic [CH_NUM-1:0] bounce_flag
);

    // The last counter value of a run: when a differing sample arrives at
    // this count, the run is complete. The counter never needs to go past it.
    localparam logic [CNTR_WIDTH-1:0] RISE_LAST = RISE_CNTR_VALUE - CNTR_WIDTH'(1'b1);
    localparam logic [CNTR_WIDTH-1:0] FALL_LAST = FALL_CNTR_VALUE - CNTR_WIDTH'(1'b1);

    logic [CH_NUM-1:0] w_q;
    logic              r_all_deb;

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic                  w_n;
            logic                  w_s;
            logic [1:0]            r_sync;
            logic                  r_q;
            logic [CNTR_WIDTH-1:0] r_cnt;
            logic                  r_rise;
            logic                  r_fall;
            logic                  r_bounce;

            logic [CNTR_WIDTH-1:0] w_last;
            logic [CNTR_WIDTH-1:0] w_cnt_nxt;
            logic                  w_q_nxt;
            logic                  w_rise_nxt;
            logic                  w_fall_nxt;
            logic                  w_bounce_set;
            logic                  w_bounce_nxt;

            // Polarity normalisation: 1 always means "released/good".
            assign w_n = signal_b[gi] ^ ACTIVE_HIGH[gi];
            assign w_s = r_sync[1];

            // The run length depends on the direction being qualified.
            assign w_last = r_q ? FALL_LAST : RISE_LAST;

            // Two-flop synchroniser on the normalised input.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= 2'b00;
                end else begin
                    r_sync <= {r_sync[0], w_n};
                end
            end

            // Run counter, qualified-state toggle, strobe and abort detection.
            always_comb begin
                w_cnt_nxt    = r_cnt;
                w_q_nxt      = r_q;
                w_rise_nxt   = 1'b0;
                w_fall_nxt   = 1'b0;
                w_bounce_set = 1'b0;
                if (w_s == r_q) begin
                    // An agreeing sample ends any run in progress. A nonzero
                    // count here means the run was aborted.
                    w_cnt_nxt    = {CNTR_WIDTH{1'b0}};
                    w_bounce_set = (r_cnt != {CNTR_WIDTH{1'b0}});
                end else if (r_cnt == w_last) begin
                    // The target-th consecutive differing sample qualifies
                    // the new state.
                    w_cnt_nxt  = {CNTR_WIDTH{1'b0}};
                    w_q_nxt    = ~r_q;
                    w_rise_nxt = ~r_q;
                    w_fall_nxt = r_q;
                end else begin
                    w_cnt_nxt = r_cnt + CNTR_WIDTH'(1'b1);
                end
            end

            // Sticky bounce flag: a new abort outranks a simultaneous clear.
            always_comb begin
                if (w_bounce_set) begin
                    w_bounce_nxt = 1'b1;
                end else if (clr_flags) begin
                    w_bounce_nxt = 1'b0;
                end else begin
                    w_bounce_nxt = r_bounce;
                end
            end

            // Per-channel state registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q      <= 1'b0;
                    r_cnt    <= {CNTR_WIDTH{1'b0}};
                    r_rise   <= 1'b0;
                    r_fall   <= 1'b0;
                    r_bounce <= 1'b0;
                end else begin
                    r_q      <= w_q_nxt;
                    r_cnt    <= w_cnt_nxt;
                    r_rise   <= w_rise_nxt;
                    r_fall   <= w_fall_nxt;
                    r_bounce <= w_bounce_nxt;
                end
            end

            // Pin-polarity view of q. During reset this reads as ACTIVE_HIGH,
            // which is "asserted / not ready".
            assign signal_deb[gi]  = r_q ^ ACTIVE_HIGH[gi];
            assign rise_pls[gi]    = r_rise;
            assign fall_pls[gi]    = r_fall;
            assign bounce_flag[gi] = r_bounce;
            assign w_q[gi]         = r_q;
        end
    endgenerate

    // All-channels-qualified flag, registered from q (one cycle behind).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_all_deb <= 1'b0;
        end else begin
            r_all_deb <= &w_q;
        end
    end

    assign all_deb = r_all_deb;

endmodule

// File: tb/tb_ipm2l_hsstlp_rst_debounce_mc_v2_0.sv
// ----------------------------------------------------------------------------
// Testbench for ipm2l_hsstlp_rst_debounce_mc_v2_0
// CH_NUM=2, CNTR_WIDTH=4, RISE=8, FALL=3, ACTIVE_HIGH=2'b10.
// Each table step drives inputs on a falling edge and holds them for ncyc
// rising edges. The outputs are then compared on the next falling edge, or
// #1 later when ncyc == 0, to observe the asynchronous reset. Expected values
// were derived by hand from the timing rules: with RISE=8 the first changed
// q appears 10 edges after the input changes, and with FALL=3 it appears
// 5 edges after.
// ----------------------------------------------------------------------------
module tb_ipm2l_hsstlp_rst_debounce_mc_v2_0;

    logic       clk;
    logic       rst_n;
    logic [1:0] signal_b;
    logic       clr_flags;
    logic [1:0] signal_deb;
    logic [1:0] rise_pls;
    logic [1:0] fall_pls;
    logic       all_deb;
    logic [1:0] bounce_flag;

    ipm2l_hsstlp_rst_debounce_mc_v2_0 #(
        .CH_NUM          (2),
        .CNTR_WIDTH      (4),
        .RISE_CNTR_VALUE (4'd8),
        .FALL_CNTR_VALUE (4'd3),
        .ACTIVE_HIGH     (2'b10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal_b    (signal_b),
        .clr_flags   (clr_flags),
        .signal_deb  (signal_deb),
        .rise_pls    (rise_pls),
        .fall_pls    (fall_pls),
        .all_deb     (all_deb),
        .bounce_flag (bounce_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [1:0] pins;
        logic       clr;
        int         ncyc;
        logic [1:0] deb;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       all;
        logic [1:0] bounce;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic [1:0] p, input logic c, input int n,
                       input logic [1:0] d, input logic [1:0] ri, input logic [1:0] fa,
                       input logic al, input logic [1:0] b);
        vec_t v;
        v.rst_n = r; v.pins = p; v.clr = c; v.ncyc = n;
        v.deb = d; v.rise = ri; v.fall = fa; v.all = al; v.bounce = b;
        vecs.push_back(v);
    endtask

    task automatic chk2(input int step, input string nm, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL step%0d %s got=%b exp=%b", step, nm, got, exp);
        end
    endtask

    initial begin
        vec_t e;
        rst_n     = 1'b0;
        signal_b  = 2'b01;
        clr_flags = 1'b0;

        // 1. reset values, then release with both channels qualifying together
        add(1'b0, 2'b01, 1'b0, 3, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00);
        add(1'b1, 2'b01, 1'b0, 9, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00);
        add(1'b1, 2'b01, 1'b0, 1, 2'b01, 2'b11, 2'b00, 1'b0, 2'b00);
        add(1'b1, 2'b01, 1'b0, 1, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00);
        // drop ch0 so a rise can be re-qualified (all_deb lags by one cycle)
        add(1'b1, 2'b00, 1'b0, 5, 2'b00, 2'b00, 2'b01, 1'b1, 2'b00);
        add(1'b1, 2'b00, 1'b0, 1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        // 2. rise bounce: 5 high, 1 low, then high held
        add(1'b1, 2'b01, 1'b0, 5, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        add(1'b1, 2'b00, 1'b0, 1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        add(1'b1, 2'b01, 1'b0, 1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        add(1'b1, 2'b01, 1'b0, 1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01);
        add(1'b1, 2'b01, 1'b0, 7, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01);
        add(1'b1, 2'b01, 1'b0, 1, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01);
        add(1'b1, 2'b01, 1'b0, 1, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01);
        // 3. fall filter: clear flags, 2-cycle low glitch, then a real fall
        add(1'b1, 2'b01, 1'b1, 1, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00);
        add(1'b1, 2'b00, 1'b0, 2, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00);
        add(1'b1, 2'b01, 1'b0, 2, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00);
        add(1'b1, 2'b01, 1'b0, 1, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01);
        add(1'b1, 2'b00, 1'b0, 4, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01);
        add(1'b1, 2'b00, 1'b0, 1, 2'b00, 2'b00, 2'b01, 1'b1, 2'b01);
        add(1'b1, 2'b00, 1'b0, 1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01);
        // 4. clear coincident with a ch1 abort: set wins, ch0 bit clears
        add(1'b1, 2'b10, 1'b0, 1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01);
        add(1'b1, 2'b00, 1'b0, 2, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01);
        add(1'b1, 2'b00, 1'b1, 1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b10);
        add(1'b1, 2'b00, 1'b0, 2, 2'b00, 2'b00, 2'b00, 1'b0, 2'b10);
        add(1'b1, 2'b00, 1'b1, 1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        add(1'b1, 2'b00, 1'b0, 1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        // 5. async reset after 6 of 8 rise samples, then a full run is needed
        add(1'b1, 2'b01, 1'b0, 8, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        add(1'b0, 2'b01, 1'b0, 0, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00);
        add(1'b0, 2'b01, 1'b0, 2, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00);
        add(1'b1, 2'b01, 1'b0, 9, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00);
        add(1'b1, 2'b01, 1'b0, 1, 2'b01, 2'b11, 2'b00, 1'b0, 2'b00);
        add(1'b1, 2'b01, 1'b0, 1, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00);
        // 6. ch1 (active high) falls, bounces, re-rises; ch0 stays put
        add(1'b1, 2'b11, 1'b0, 4, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00);
        add(1'b1, 2'b11, 1'b0, 1, 2'b11, 2'b00, 2'b10, 1'b1, 2'b00);
        add(1'b1, 2'b01, 1'b0, 3, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
        add(1'b1, 2'b11, 1'b0, 1, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00);
        add(1'b1, 2'b01, 1'b0, 3, 2'b11, 2'b00, 2'b00, 1'b0, 2'b10);
        add(1'b1, 2'b01, 1'b0, 6, 2'b11, 2'b00, 2'b00, 1'b0, 2'b10);
        add(1'b1, 2'b01, 1'b0, 1, 2'b01, 2'b10, 2'b00, 1'b0, 2'b10);
        add(1'b1, 2'b01, 1'b0, 1, 2'b01, 2'b00, 2'b00, 1'b1, 2'b10);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n     = vecs[i].rst_n;
            signal_b  = vecs[i].pins;
            clr_flags = vecs[i].clr;
            exp_q.push_back(vecs[i]);
            if (vecs[i].ncyc == 0) begin
                #1;
            end else begin
                repeat (vecs[i].ncyc) @(posedge clk);
                @(negedge clk);
            end
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL step%0d scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                chk2(i, "signal_deb",  signal_deb,        e.deb);
                chk2(i, "rise_pls",    rise_pls,          e.rise);
                chk2(i, "fall_pls",    fall_pls,          e.fall);
                chk2(i, "all_deb",     {1'b0, all_deb},   {1'b0, e.all});
                chk2(i, "bounce_flag", bounce_flag,       e.bounce);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ipm2l_hsstlp_rst_debounce_mc_v2_0.md
# ipm2l_hsstlp_rst_debounce_mc_v2_0

Multi-channel, bidirectional debounce filter for the HSSTLP reset/status inputs, such as PLL lock, CDR lock, external reset pins and signal-detect. Each channel synchronises its raw input and normalises it for polarity. The channel changes its qualified state only after a configurable run of consecutive opposite samples, with separate rise and fall qualification lengths. It also reports edge strobes, an all-channels-qualified flag and sticky bounce flags. It sits between the raw pins/status lines and the HSSTLP reset sequencers.

## Interface
- CH_NUM, 4: number of independent channels (≥1).
- CNTR_WIDTH, 12: qualification counter width; must satisfy 2^CNTR_WIDTH > max(RISE_CNTR_VALUE, FALL_CNTR_VALUE).
- RISE_CNTR_VALUE, 12'd2048: consecutive normalised-1 samples needed to qualify 0→1 (≥1).
- FALL_CNTR_VALUE, 12'd1: consecutive normalised-0 samples needed to qualify 1→0 (≥1). A value of 1 gives immediate deassert.
- ACTIVE_HIGH, {CH_NUM{1'b0}}: per-channel bit. 0 = input active low (normalised = pin); 1 = active high (normalised = ~pin).
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous, active-low reset.
- signal_b  input  CH_NUM  raw asynchronous inputs.
- clr_flags  input  1  one-cycle pulse; clears all bounce_flag bits.
- signal_deb  output  CH_NUM  qualified outputs, pin polarity: bit = q[i] ^ ACTIVE_HIGH[i].
- rise_pls  output  CH_NUM  one-cycle strobe when q[i] goes 0→1.
- fall_pls  output  CH_NUM  one-cycle strobe when q[i] goes 1→0.
- all_deb  output  1  registered AND of all q[i].
- bounce_flag  output  CH_NUM  sticky: a qualification run was aborted.

## Operation
- Normalisation: n[i] = signal_b[i] ^ ACTIVE_HIGH[i]. q[i] = 1 means "released/good".
- Synchroniser: 2 flops per channel on n[i]. The second-stage output is the sample s[i]. Both stages reset to 0.
- Counter cnt[i]:
  - If s[i] == q[i]: cnt cleared to 0.
  - Else, if cnt == target−1: q[i] toggles and cnt clears to 0, where target = RISE_CNTR_VALUE when q=0 and FALL_CNTR_VALUE when q=1.
  - Else: cnt increments by 1.
  - cnt never exceeds target−1, so there is no wrap.
- q[i] therefore changes on the edge that registers the target-th consecutive differing sample.
- Strobes:
  - rise_pls[i] / fall_pls[i] are registered and asserted in the same cycle the new q[i] is first visible.
  - Each strobe is exactly one cycle, and the two are never simultaneous on one channel.
- all_deb: registered AND over q, so it lags q by one cycle.
- bounce_flag[i]:
  - Set when s[i] == q[i] while cnt[i] != 0, i.e. an aborted run.
  - Cleared by clr_flags.
  - If set and clear occur in the same cycle, set wins.
- Channels are fully independent; no cross-channel ordering.
- Reset values, all outputs:
  - q = 0 and cnt = 0.
  - signal_deb = ACTIVE_HIGH, i.e. outputs read as asserted/not-ready during reset.
  - rise_pls = fall_pls = 0, all_deb = 0, bounce_flag = 0.
- Reset mid-qualification: all state is discarded immediately and asynchronously. After release, a full RISE_CNTR_VALUE run is needed again.

## Timing
- Pin-to-s latency: 2 clk.
- Rise: if s[i]=1 (with q=0) in cycles t..t+R−1, then q[i]=1 from cycle t+R. The total pin-to-signal_deb latency is 2+R cycles after the pin settles.
- Fall: same rule with F = FALL_CNTR_VALUE. With F=1, q drops the cycle after the first s=0.
- Any opposite sample inside a run restarts counting from 0 on the next differing sample.
- Input pulses narrower than 1 clk may be missed. This is acceptable, since the block is a level filter.
- all_deb rises 1 clk after the last channel's q rises, and falls 1 clk after any q falls.

## Test plan
Bench parameters: CH_NUM=2, CNTR_WIDTH=4, RISE=8, FALL=3, ACTIVE_HIGH=2'b10.

1. **Reset values:** hold rst_n=0 → signal_deb=2'b10, all_deb=0, strobes=0, bounce_flag=0. Release with ch0 pin=1 and ch1 pin=0 held → q0 and q1 rise 2+8=10 cycles after release. rise_pls=2'b11 for one cycle; all_deb=1 one cycle later.
2. **Rise bounce:** ch0 pin=1 for 5 cycles, 0 for 1, then 1 held → no qualification at 8 cycles. q0 rises 8 cycles after the restart, and bounce_flag[0]=1.
3. **Fall filter:** with q0=1, drive pin0=0 for 2 cycles then back to 1 → no fall, bounce_flag[0] set. Then pin0=0 held for 3 cycles → fall_pls[0] one cycle, and all_deb drops 1 cycle later.
4. **Clear vs set:** pulse clr_flags in the same cycle as an abort on ch1 → bounce_flag[1] stays 1. clr_flags alone on a later cycle → 0.
5. **Async reset mid-run:** assert rst_n=0 after 6 of 8 rise samples → outputs return to reset values immediately. After release, q requires a full 8-sample run.
6. **Independence/polarity:** toggle ch1 pin high/low with active-high polarity while ch0 is stable → ch0 signal_deb and cnt are unaffected. ch1 signal_deb = ~q1 throughout.
